// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo 16-bit I2S transmitter for the 12.288 MHz PLL clock.
// A 4-deep (FIFO_DEPTH) sample-pair FIFO feeds one pair per 256-cycle frame
// (48 kHz). audio_sclk = cnt[1], audio_lrck = cnt[7], and the data bit for
// slot cnt[6:2] are all registered, so the three pins are mutually aligned.
// Build option: define AUDIO_I2S_UNDERRUN_CNT_EN to build the saturating
// underrun counter; otherwise underrun_cnt is tied to zero.

module audio_i2s_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  logic                        clk_audio,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        s_valid,
  input  logic [2*DATA_W-1:0]         s_data,
  output logic                        s_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        audio_sclk,
  output logic                        audio_lrck,
  output logic                        audio_dac,
  output logic [15:0]                 underrun_cnt
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  CNT_LAST = 8'd255;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   state_p0, state_nxt;
  logic [7:0]               cnt_p0;
  logic                     vld_p0;
  logic                     pop_p0;
  logic                     push;
  logic                     fifo_empty;
  logic [AW:0]              wr_ptr, rd_ptr, level;
  logic [2*DATA_W-1:0]      mem [FIFO_DEPTH];
  logic signed [DATA_W-1:0] left_p0, right_p0;
  logic                     sclk_p1, lrck_p1, dac_p1;

  // Slot 0 is the I2S one-bit delay, slots 1..DATA_W carry MSB..LSB, the rest are 0.
  function automatic logic slot_bit(input logic signed [DATA_W-1:0] smp,
                                    input logic [4:0] k);
    logic [DATA_W-1:0] sh;
    if (k == 5'd0 || int'(k) > DATA_W) return 1'b0;
    sh = $unsigned(smp) << (k - 5'd1);
    return sh[DATA_W-1];
  endfunction

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (level == '0);
  assign s_ready    = (level != FULL_LVL);
  assign fifo_level = level;
  assign push       = s_valid && s_ready;
  assign vld_p0     = (state_p0 != IDLE);
  assign pop_p0     = vld_p0 && (cnt_p0 == 8'd0);

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = (cnt_p0 == CNT_LAST) ? IDLE : DRAIN;
      DRAIN:   if (cnt_p0 == CNT_LAST) state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: run state and frame counter (held at 0 while idle)
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= vld_p0 ? cnt_p0 + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)                  wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0 && !fifo_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_audio) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk_audio) begin
    if (pop_p0) begin
      if (fifo_empty) begin
        left_p0  <= '0;
        right_p0 <= '0;
      end else begin
        left_p0  <= $signed(mem[rd_ptr[AW-1:0]][2*DATA_W-1:DATA_W]);
        right_p0 <= $signed(mem[rd_ptr[AW-1:0]][DATA_W-1:0]);
      end
    end
  end

  // Stage p1: registered pins; data only moves on the sclk falling edge
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      sclk_p1 <= 1'b0;
      lrck_p1 <= 1'b0;
      dac_p1  <= 1'b0;
    end else begin
      sclk_p1 <= cnt_p0[1];
      lrck_p1 <= cnt_p0[7];
      if (cnt_p0[1:0] == 2'b00)
        dac_p1 <= cnt_p0[7] ? slot_bit(right_p0, cnt_p0[6:2])
                            : slot_bit(left_p0,  cnt_p0[6:2]);
    end
  end

  assign audio_sclk = sclk_p1;
  assign audio_lrck = lrck_p1;
  assign audio_dac  = dac_p1;

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  logic [15:0] under_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p1: saturating count of frames started with an empty FIFO
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n)                  under_p1 <= '0;
    else if (pop_p0 && fifo_empty) under_p1 <= sat_inc(under_p1);
  end

  assign underrun_cnt = under_p1;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo 16-bit I2S transmitter for the 12.288 MHz audio clock produced by the core PLL. Accepts left/right sample pairs through a valid/ready port into a 4-entry FIFO. Serialises them at 48 kHz (256 clocks per frame) onto the audio DAC pins (bit clock, word select, data). Sits directly downstream of the PLL's 12.288 MHz output. Any clock-domain crossing from the CPU/mixer side is done upstream of this block.

## Interface
- `FIFO_DEPTH`, default 4, sample-pair FIFO depth; power of two, 2..16.
- `clk_audio` in 1: 12.288 MHz audio clock from the PLL.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; sampled only as described under Operation.
- `s_valid` in 1: sample pair present on `s_data`.
- `s_data` in 32: sample pair; `{left[15:0], right[15:0]}`, two's complement.
- `s_ready` out 1: FIFO can accept a pair this cycle.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `audio_sclk` out 1: bit clock, 3.072 MHz (64 fs).
- `audio_lrck` out 1: word select; 0 = left, 1 = right.
- `audio_dac` out 1: serial data.
- `underrun_cnt` out 16: frames started with an empty FIFO (see Configuration).

## Operation
- Frame counter `cnt[7:0]` increments every `clk_audio` cycle in RUN and DRAIN, and wraps 255→0.
- Outputs are registered from `cnt`, so all three pins carry one cycle of latency and stay mutually aligned:
  - `audio_sclk` = `cnt[1]`.
  - `audio_lrck` = `cnt[7]`.
- Bit slot `k` = `cnt[6:2]` (0..31) within each half-frame.
  - Slot 0 carries 0 (the I2S one-bit delay).
  - Slots 1..16 carry sample bits 15..0, MSB first.
  - Slots 17..31 carry 0.
  - `audio_dac` changes only on cycles where `cnt[1:0]` = 0, i.e. on the falling edge of `audio_sclk`.
- Frame pop at `cnt` = 0:
  - FIFO non-empty: pop one pair into the left and right shift holds.
  - FIFO empty: load zeros into both holds and count an underrun.
- FIFO push: occurs when `s_valid && s_ready`. `s_ready` = not full.
  - Simultaneous push and pop on a non-full FIFO: both take effect and the level is unchanged.
  - Full FIFO: `s_ready` stays 0 even in the pop cycle (no same-cycle bypass).
- State machine:
  - IDLE: `cnt` held at 0, all pins 0; FIFO still accepts pushes. Goes to RUN when `enable` = 1.
  - RUN: normal serialisation. Goes to DRAIN when `enable` = 0.
  - DRAIN: finishes the current frame. At `cnt` = 255 goes to IDLE, or to RUN if `enable` has returned to 1.
- Reset (asynchronous, at any point, including mid-frame):
  - State = IDLE, `cnt` = 0, FIFO emptied.
  - `audio_sclk`, `audio_lrck`, `audio_dac` = 0.
  - `fifo_level` = 0, `s_ready` = 1, `underrun_cnt` = 0.

## Timing
- First frame: if `enable` rises in cycle T, `cnt` = 0 in T+1 (frame pop), and `audio_lrck` and `audio_sclk` first reflect that frame in T+2.
- First data: the left MSB appears on `audio_dac` at `cnt` = 4 plus one cycle of register latency.
- Frame period is exactly 256 cycles (48.000 kHz); `audio_lrck` high for 128 cycles, low for 128.
- Input latency: a pair pushed at cycle P, into an empty FIFO while running, is output in the next frame whose pop cycle is strictly after P.
- `fifo_level` and `s_ready` update in the cycle after the push or pop edge.

## Configuration
- `AUDIO_I2S_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` increments by 1 at each empty-FIFO frame pop while in RUN or DRAIN.
  - It saturates at 0xFFFF and clears only on reset.
- Not defined: `underrun_cnt` is tied to 0 and no counter logic is built. Output silence on underrun is identical in both builds.

## Test plan
- Reset, `enable` = 1, one push of 0x8001_7FFE: left slots 1..16 = 1,0×14,1 and right slots 1..16 = 0,1×14,0. All other slots 0.
- Measure pin timing over 3 frames:
  - `audio_lrck` period is exactly 256 cycles; `audio_sclk` period is 4 cycles.
  - `audio_dac` transitions only one cycle after `cnt[1:0]` = 0.
- Push 5 pairs with `enable` = 0: `s_ready` drops after the 4th push and `fifo_level` = 4. After `enable` = 1, one pop per frame drains the FIFO in order.
- Run with the FIFO empty for 3 frames (macro defined): `audio_dac` stays 0 and `underrun_cnt` = 3. With the macro undefined, `underrun_cnt` = 0.
- Drop `enable` at `cnt` = 100: the frame completes through `cnt` = 255, then IDLE with all pins 0. Re-raise `enable` during DRAIN: goes straight to RUN with no gap frame.
- Assert `reset_n` low mid-frame with 3 entries queued: all outputs go to 0 immediately, `fifo_level` = 0 and `s_ready` = 1 after release.
